// File: rtl/mbist_addr_gen.sv
// MBIST address generator: walks the SRAM address range up or down per march
// element, reloads on element/pattern start, and flags the last address.
module mbist_addr_gen #(
  parameter int unsigned             BIST_ADDR_WD    = 9,
  parameter logic [BIST_ADDR_WD-1:0] BIST_ADDR_START = 9'h000,
  parameter logic [BIST_ADDR_WD-1:0] BIST_ADDR_END   = 9'h1F8,
  parameter int unsigned             BIST_ADDR_STEP  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    bist_run,
  input  logic                    run_addr,
  input  logic                    run_sti,
  input  logic                    run_pat,
  input  logic                    addr_down,
  output logic [BIST_ADDR_WD-1:0] bist_addr,
  output logic                    addr_dir,
  output logic                    last_addr
);

  // One extra bit so overflow past END and underflow below zero are visible.
  localparam int unsigned EXT_WD = BIST_ADDR_WD + 1;

  typedef logic [EXT_WD-1:0] ext_t;

  localparam ext_t START_X = EXT_WD'(BIST_ADDR_START);
  localparam ext_t END_X   = EXT_WD'(BIST_ADDR_END);
  localparam ext_t STEP_X  = EXT_WD'(BIST_ADDR_STEP);

  // ST_IDLE means the next cycle with bist_run=1 is the load cycle.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [BIST_ADDR_WD-1:0] addr_nxt;
  logic                    dir_nxt;
  logic                    last_nxt;
  ext_t                    up_sum;
  ext_t                    dn_diff;

  // Next-state, next-address and last-address flag for the coming edge.
  always_comb begin
    state_nxt = state;
    addr_nxt  = bist_addr;
    dir_nxt   = addr_dir;
    up_sum    = {1'b0, bist_addr} + STEP_X;
    dn_diff   = {1'b0, bist_addr} - STEP_X;

    if (!bist_run) begin
      state_nxt = ST_IDLE;
      addr_nxt  = BIST_ADDR_START;
      dir_nxt   = 1'b0;
    end else if ((state == ST_IDLE) || run_sti || run_pat) begin
      // Load cycle or new element/pattern: restart in the requested order.
      state_nxt = ST_RUN;
      dir_nxt   = addr_down;
      addr_nxt  = addr_down ? BIST_ADDR_END : BIST_ADDR_START;
    end else if (run_addr) begin
      if (last_addr) begin
        // Wrap to the first address of the same direction.
        addr_nxt = addr_dir ? BIST_ADDR_END : BIST_ADDR_START;
      end else if (!addr_dir) begin
        addr_nxt = (up_sum > END_X) ? BIST_ADDR_END : up_sum[BIST_ADDR_WD-1:0];
      end else begin
        // MSB set means the subtraction went below zero.
        addr_nxt = (dn_diff[BIST_ADDR_WD] || (dn_diff < START_X))
                   ? BIST_ADDR_START : dn_diff[BIST_ADDR_WD-1:0];
      end
    end

    // Flag computed from the next address so it lands with bist_addr.
    last_nxt = bist_run && (dir_nxt ? (addr_nxt == BIST_ADDR_START)
                                    : (addr_nxt == BIST_ADDR_END));
  end

  // State and output registers; synchronous reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      bist_addr <= BIST_ADDR_START;
      addr_dir  <= 1'b0;
      last_addr <= 1'b0;
    end else begin
      state     <= state_nxt;
      bist_addr <= addr_nxt;
      addr_dir  <= dir_nxt;
      last_addr <= last_nxt;
    end
  end

endmodule

// File: tb/tb_mbist_addr_gen.sv
// Directed bench for mbist_addr_gen: default instance plus STEP=3 and
// STEP=4/END=0x1F6 instances for saturation at both ends of the range.
module tb_mbist_addr_gen;

  logic clk = 1'b0;
  logic rst;

  // Default-parameter instance stimulus and outputs.
  logic       run, ra, sti, pat, dn;
  logic [8:0] addr_a;
  logic       dir_a, last_a;

  // Shared stimulus for the stepped instances.
  logic       run2, ra2, sti2, pat2, dn2;
  logic [8:0] addr_b, addr_c;
  logic       dir_b, last_b, dir_c, last_c;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  mbist_addr_gen dut (
    .clk(clk), .rst(rst), .bist_run(run), .run_addr(ra), .run_sti(sti),
    .run_pat(pat), .addr_down(dn), .bist_addr(addr_a), .addr_dir(dir_a),
    .last_addr(last_a)
  );

  mbist_addr_gen #(.BIST_ADDR_STEP(3)) dut3 (
    .clk(clk), .rst(rst), .bist_run(run2), .run_addr(ra2), .run_sti(sti2),
    .run_pat(pat2), .addr_down(dn2), .bist_addr(addr_b), .addr_dir(dir_b),
    .last_addr(last_b)
  );

  mbist_addr_gen #(.BIST_ADDR_END(9'h1F6), .BIST_ADDR_STEP(4)) dut4 (
    .clk(clk), .rst(rst), .bist_run(run2), .run_addr(ra2), .run_sti(sti2),
    .run_pat(pat2), .addr_down(dn2), .bist_addr(addr_c), .addr_dir(dir_c),
    .last_addr(last_c)
  );

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_a();
    ra = 1'b1;
    step();
    ra = 1'b0;
  endtask

  task automatic pulse_b();
    ra2 = 1'b1;
    step();
    ra2 = 1'b0;
  endtask

  initial begin
    run = 0; ra = 0; sti = 0; pat = 0; dn = 0;
    run2 = 0; ra2 = 0; sti2 = 0; pat2 = 0; dn2 = 0;
    rst = 1'b1;

    // Reset with random inputs for two cycles.
    for (int c = 0; c < 2; c++) begin
      run = 1'($urandom); ra = 1'($urandom); sti = 1'($urandom);
      pat = 1'($urandom); dn = 1'($urandom);
      run2 = 1'($urandom); ra2 = 1'($urandom); dn2 = 1'($urandom);
      step();
      chk("rst_addr", 10'(addr_a), 10'h000);
      chk("rst_dir",  10'(dir_a),  10'h0);
      chk("rst_last", 10'(last_a), 10'h0);
      chk("rst_addr3", 10'(addr_b), 10'h000);
    end
    run = 0; ra = 0; sti = 0; pat = 0; dn = 0;
    run2 = 0; ra2 = 0; sti2 = 0; pat2 = 0; dn2 = 0;
    rst = 1'b0;
    step();
    chk("idle_addr", 10'(addr_a), 10'h000);
    chk("idle_last", 10'(last_a), 10'h0);

    // Load cycle, up.
    run = 1'b1;
    step();
    chk("load_up_addr", 10'(addr_a), 10'h000);
    chk("load_up_dir",  10'(dir_a),  10'h0);
    chk("load_up_last", 10'(last_a), 10'h0);

    // Full ascending walk.
    for (int i = 1; i <= 'h1F8; i++) begin
      pulse_a();
      chk("up_addr", 10'(addr_a), 10'(i));
      chk("up_last", 10'(last_a), 10'(i == 'h1F8));
    end

    // run_sti together with run_addr at last: reload downwards.
    sti = 1; ra = 1; dn = 1;
    step();
    sti = 0; ra = 0;
    chk("sti_dn_addr", 10'(addr_a), 10'h1F8);
    chk("sti_dn_dir",  10'(dir_a),  10'h1);
    chk("sti_dn_last", 10'(last_a), 10'h0);

    // Full descending walk.
    for (int i = 1; i <= 'h1F8; i++) begin
      pulse_a();
      chk("dn_addr", 10'(addr_a), 10'('h1F8 - i));
      chk("dn_last", 10'(last_a), 10'(i == 'h1F8));
      chk("dn_dir",  10'(dir_a),  10'h1);
    end

    // Down wrap at last goes back to END.
    pulse_a();
    chk("dn_wrap_addr", 10'(addr_a), 10'h1F8);
    chk("dn_wrap_dir",  10'(dir_a),  10'h1);

    // run_pat reloads upwards.
    pat = 1; dn = 0;
    step();
    pat = 0;
    chk("pat_up_addr", 10'(addr_a), 10'h000);
    chk("pat_up_dir",  10'(dir_a),  10'h0);
    for (int i = 1; i <= 'h1F8; i++) pulse_a();
    chk("up2_addr", 10'(addr_a), 10'h1F8);
    chk("up2_last", 10'(last_a), 10'h1);

    // Hold at last while run_addr is low.
    for (int c = 0; c < 3; c++) step();
    chk("hold_addr", 10'(addr_a), 10'h1F8);
    chk("hold_last", 10'(last_a), 10'h1);

    // Up wrap at last.
    pulse_a();
    chk("up_wrap_addr", 10'(addr_a), 10'h000);
    chk("up_wrap_dir",  10'(dir_a),  10'h0);
    chk("up_wrap_last", 10'(last_a), 10'h0);

    // Abandon mid-count, then restart downwards.
    for (int i = 1; i <= 'hA5; i++) pulse_a();
    chk("mid_addr", 10'(addr_a), 10'h0A5);
    run = 0;
    step();
    chk("drop_addr", 10'(addr_a), 10'h000);
    chk("drop_dir",  10'(dir_a),  10'h0);
    chk("drop_last", 10'(last_a), 10'h0);
    run = 1; dn = 1;
    step();
    chk("reload_addr", 10'(addr_a), 10'h1F8);
    chk("reload_dir",  10'(dir_a),  10'h1);
    chk("reload_last", 10'(last_a), 10'h0);

    // Stepped instances: load up.
    run2 = 1;
    step();
    chk("s3_load", 10'(addr_b), 10'h000);
    chk("s4_load", 10'(addr_c), 10'h000);
    for (int i = 1; i <= 125; i++) pulse_b();
    chk("s4_pre_sat", 10'(addr_c), 10'h1F4);
    chk("s4_pre_last", 10'(last_c), 10'h0);
    pulse_b();
    chk("s4_sat_up", 10'(addr_c), 10'h1F6);
    chk("s4_sat_last", 10'(last_c), 10'h1);
    for (int i = 127; i <= 167; i++) pulse_b();
    chk("s3_1f5", 10'(addr_b), 10'h1F5);
    chk("s3_1f5_last", 10'(last_b), 10'h0);
    pulse_b();
    chk("s3_1f8", 10'(addr_b), 10'h1F8);
    chk("s3_1f8_last", 10'(last_b), 10'h1);

    // Stepped instances: reload down.
    sti2 = 1; dn2 = 1;
    step();
    sti2 = 0;
    chk("s3_dn_load", 10'(addr_b), 10'h1F8);
    chk("s4_dn_load", 10'(addr_c), 10'h1F6);
    chk("s4_dn_dir",  10'(dir_c),  10'h1);
    for (int i = 1; i <= 125; i++) pulse_b();
    chk("s4_dn_pre", 10'(addr_c), 10'h002);
    chk("s4_dn_pre_last", 10'(last_c), 10'h0);
    pulse_b();
    chk("s4_sat_dn", 10'(addr_c), 10'h000);
    chk("s4_sat_dn_last", 10'(last_c), 10'h1);
    chk("s3_dn_mid", 10'(addr_b), 10'h07E);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
